// File: rtl/gather_bytes_if.sv
// Handshake bundle for gather_bytes: FWFT input side, flush control and
// the wide output write port. The design uses the slave modport.
interface gather_bytes_if #(
    parameter int C_IN_WIDTH  = 8,
    parameter int C_OUT_WIDTH = 32,
    parameter int C_CNT_WIDTH = 3
);
    logic                   INDATA_EN;
    logic [C_IN_WIDTH-1:0]  INDATA;
    logic                   INDATA_RD_EN;
    logic                   FLUSH;
    logic                   FLUSHED;
    logic [C_OUT_WIDTH-1:0] OUTDATA;
    logic [C_CNT_WIDTH-1:0] OUTDATA_BYTES;
    logic                   OUTDATA_WEN;
    logic                   OUTDATA_FULL;

    modport master (
        output INDATA_EN, INDATA, FLUSH, OUTDATA_FULL,
        input  INDATA_RD_EN, FLUSHED, OUTDATA, OUTDATA_BYTES, OUTDATA_WEN
    );

    modport slave (
        input  INDATA_EN, INDATA, FLUSH, OUTDATA_FULL,
        output INDATA_RD_EN, FLUSHED, OUTDATA, OUTDATA_BYTES, OUTDATA_WEN
    );
endinterface

// File: rtl/gather_bytes.sv
// Packs narrow FWFT FIFO reads into wide output words, first chunk in the
// least significant slot; FLUSH pushes out a zero-padded partial word.
module gather_bytes #(
    parameter int C_IN_BYTES  = 1,
    parameter int C_OUT_BYTES = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    gather_bytes_if.slave bus
);
    localparam int C_IN_WIDTH  = 8 * C_IN_BYTES;
    localparam int C_OUT_WIDTH = 8 * C_OUT_BYTES;
    localparam int C_MULT      = C_OUT_BYTES / C_IN_BYTES;
    localparam int C_CNT_WIDTH = $clog2(C_OUT_BYTES + 1);

    localparam logic [C_CNT_WIDTH-1:0] LAST_POS   = C_CNT_WIDTH'(C_MULT - 1);
    localparam logic [C_CNT_WIDTH-1:0] FULL_BYTES = C_CNT_WIDTH'(C_OUT_BYTES);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [C_CNT_WIDTH-1:0] rPos;
    logic                   rOutValid;
    logic [C_OUT_WIDTH-1:0] acc;
    logic [C_OUT_WIDTH-1:0] out_data;
    logic [C_CNT_WIDTH-1:0] out_bytes;
    logic [C_OUT_WIDTH-1:0] full_word;
    logic                   rd_en;
    logic                   wen;

    assign wen   = rOutValid && !bus.OUTDATA_FULL;
    // The last chunk may only be taken if the output register will be free.
    assign rd_en = RST_N && bus.INDATA_EN && (state != DONE) &&
                   ((rPos != LAST_POS) || !rOutValid || !bus.OUTDATA_FULL);

    always_comb begin
        full_word = acc;
        full_word[(C_MULT-1)*C_IN_WIDTH +: C_IN_WIDTH] = bus.INDATA;
    end

    assign bus.INDATA_RD_EN  = rd_en;
    assign bus.OUTDATA_WEN   = wen;
    assign bus.OUTDATA       = out_data;
    assign bus.OUTDATA_BYTES = out_bytes;
    assign bus.FLUSHED       = (state == DONE);

    // acc is cleared whenever a word leaves it, so unfilled slots read as zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= RUN;
            rPos      <= '0;
            rOutValid <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_bytes <= '0;
        end else begin
            if (wen)
                rOutValid <= 1'b0;

            if (rd_en) begin
                if (rPos != LAST_POS) begin
                    acc[int'(rPos)*C_IN_WIDTH +: C_IN_WIDTH] <= bus.INDATA;
                    rPos <= rPos + 1'b1;
                end else begin
                    out_data  <= full_word;
                    out_bytes <= FULL_BYTES;
                    rOutValid <= 1'b1;
                    rPos      <= '0;
                    acc       <= '0;
                end
            end

            unique case (state)
                RUN: begin
                    if (bus.FLUSH)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.INDATA_EN) begin
                        if ((rPos != '0) && (!rOutValid || !bus.OUTDATA_FULL)) begin
                            out_data  <= acc;
                            out_bytes <= C_CNT_WIDTH'(int'(rPos) * C_IN_BYTES);
                            rOutValid <= 1'b1;
                            rPos      <= '0;
                            acc       <= '0;
                        end else if ((rPos == '0) && !rOutValid) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= bus.FLUSH ? DRAIN : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_gather_bytes.sv
// Scoreboard bench for gather_bytes (1-byte in, 4-byte out) with an FWFT
// FIFO model on the input side.
module tb_gather_bytes;
    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    gather_bytes_if #(.C_IN_WIDTH(8), .C_OUT_WIDTH(32), .C_CNT_WIDTH(3)) bus ();

    gather_bytes #(.C_IN_BYTES(1), .C_OUT_BYTES(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks      = 0;
    int failures    = 0;
    int flushed_cnt = 0;
    int write_cnt   = 0;

    logic [7:0] fifo[$];
    exp_t       sb[$];

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    function automatic void refresh_fifo();
        bus.INDATA_EN = (fifo.size() != 0);
        bus.INDATA    = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        fifo.push_back(b);
        refresh_fifo();
    endtask

    task automatic expect_word(input logic [31:0] data, input logic [2:0] bytes);
        exp_t e;
        e.data  = data;
        e.bytes = bytes;
        sb.push_back(e);
    endtask

    // One clock: sample the read strobe, take the edge, pop what was consumed.
    task automatic tick(output logic rd);
        #1;
        rd = bus.INDATA_RD_EN;
        @(posedge CLK);
        #1;
        if (rd && fifo.size() != 0)
            void'(fifo.pop_front());
        refresh_fifo();
        #1;
    endtask

    task automatic wait_flush(input int target, input string tag);
        logic rd;
        for (int i = 0; i < 20 && flushed_cnt < target; i++)
            tick(rd);
        checkOutput(tag, 64'(flushed_cnt), 64'(target));
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (bus.FLUSHED)
                flushed_cnt++;
            if (bus.OUTDATA_WEN) begin
                write_cnt++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_write", 64'(bus.OUTDATA_WEN), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("word_data", 64'(bus.OUTDATA), 64'(e.data));
                    checkOutput("word_bytes", 64'(bus.OUTDATA_BYTES), 64'(e.bytes));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic rd;
        int   base_flushed;
        int   base_writes;

        RST_N            = 1'b0;
        bus.FLUSH        = 1'b0;
        bus.OUTDATA_FULL = 1'b0;
        applyStimulus(8'h99);
        #22;
        checkOutput("reset_rd_en", 64'(bus.INDATA_RD_EN), 64'(0));
        checkOutput("reset_wen", 64'(bus.OUTDATA_WEN), 64'(0));
        checkOutput("reset_flushed", 64'(bus.FLUSHED), 64'(0));
        checkOutput("reset_outdata", 64'(bus.OUTDATA), 64'(0));
        checkOutput("reset_bytes", 64'(bus.OUTDATA_BYTES), 64'(0));
        fifo.delete();
        refresh_fifo();
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        tick(rd);

        $display("[TB] streaming two full words");
        for (int i = 1; i <= 8; i++)
            applyStimulus(8'(i));
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        for (int i = 0; i < 8; i++) begin
            tick(rd);
            checkOutput("stream_rd_en", 64'(rd), 64'(1));
            checkOutput("stream_wen_latency", 64'(bus.OUTDATA_WEN),
                        64'((i == 3) || (i == 7)));
        end
        tick(rd);
        checkOutput("stream_writes", 64'(write_cnt), 64'(2));

        $display("[TB] backpressure on the last chunk");
        bus.OUTDATA_FULL = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(8'h11 + 8'(i));
        expect_word(32'h14131211, 3'd4);
        for (int i = 0; i < 4; i++)
            tick(rd);
        checkOutput("full_wen_blocked", 64'(bus.OUTDATA_WEN), 64'(0));
        for (int i = 0; i < 4; i++)
            applyStimulus(8'h21 + 8'(i));
        expect_word(32'h24232221, 3'd4);
        for (int i = 0; i < 3; i++) begin
            tick(rd);
            checkOutput("full_rd_first3", 64'(rd), 64'(1));
        end
        for (int i = 0; i < 2; i++) begin
            tick(rd);
            checkOutput("full_rd_stalled", 64'(rd), 64'(0));
        end
        checkOutput("full_outdata_held", 64'(bus.OUTDATA), 64'(32'h14131211));
        bus.OUTDATA_FULL = 1'b0;
        #1;
        checkOutput("release_rd_en", 64'(bus.INDATA_RD_EN), 64'(1));
        checkOutput("release_wen", 64'(bus.OUTDATA_WEN), 64'(1));
        tick(rd);
        checkOutput("release_next_wen", 64'(bus.OUTDATA_WEN), 64'(1));
        checkOutput("release_next_data", 64'(bus.OUTDATA), 64'(32'h24232221));
        tick(rd);
        checkOutput("release_idle_wen", 64'(bus.OUTDATA_WEN), 64'(0));

        $display("[TB] flush of a two-byte partial word");
        base_flushed = flushed_cnt;
        base_writes  = write_cnt;
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        expect_word(32'h0000BBAA, 3'd2);
        tick(rd);
        tick(rd);
        bus.FLUSH = 1'b1;
        tick(rd);
        bus.FLUSH = 1'b0;
        wait_flush(base_flushed + 1, "partial_flushed");
        checkOutput("partial_writes", 64'(write_cnt - base_writes), 64'(1));
        tick(rd);
        checkOutput("partial_flushed_single", 64'(bus.FLUSHED), 64'(0));

        $display("[TB] empty flush and flush during FLUSHED");
        base_writes = write_cnt;
        bus.FLUSH = 1'b1;
        tick(rd);
        bus.FLUSH = 1'b0;
        checkOutput("empty_flushed_early", 64'(bus.FLUSHED), 64'(0));
        tick(rd);
        checkOutput("empty_flushed_two", 64'(bus.FLUSHED), 64'(1));
        bus.FLUSH = 1'b1;
        tick(rd);
        bus.FLUSH = 1'b0;
        checkOutput("reflush_gap", 64'(bus.FLUSHED), 64'(0));
        tick(rd);
        checkOutput("reflush_second", 64'(bus.FLUSHED), 64'(1));
        tick(rd);
        checkOutput("reflush_end", 64'(bus.FLUSHED), 64'(0));
        checkOutput("empty_no_write", 64'(write_cnt - base_writes), 64'(0));

        $display("[TB] flush with six bytes queued");
        base_flushed = flushed_cnt;
        base_writes  = write_cnt;
        for (int i = 0; i < 6; i++)
            applyStimulus(8'h31 + 8'(i));
        expect_word(32'h34333231, 3'd4);
        expect_word(32'h00003635, 3'd2);
        bus.FLUSH = 1'b1;
        tick(rd);
        bus.FLUSH = 1'b0;
        wait_flush(base_flushed + 1, "six_flushed");
        checkOutput("six_writes", 64'(write_cnt - base_writes), 64'(2));
        tick(rd);

        $display("[TB] reset mid-word");
        base_flushed = flushed_cnt;
        base_writes  = write_cnt;
        for (int i = 0; i < 3; i++)
            applyStimulus(8'h41 + 8'(i));
        for (int i = 0; i < 3; i++)
            tick(rd);
        for (int i = 0; i < 4; i++)
            applyStimulus(8'h51 + 8'(i));
        RST_N = 1'b0;
        #1;
        checkOutput("midreset_outdata", 64'(bus.OUTDATA), 64'(0));
        checkOutput("midreset_bytes", 64'(bus.OUTDATA_BYTES), 64'(0));
        checkOutput("midreset_rd_en", 64'(bus.INDATA_RD_EN), 64'(0));
        checkOutput("midreset_wen", 64'(bus.OUTDATA_WEN), 64'(0));
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        expect_word(32'h54535251, 3'd4);
        for (int i = 0; i < 6; i++)
            tick(rd);
        checkOutput("midreset_writes", 64'(write_cnt - base_writes), 64'(1));
        checkOutput("midreset_no_flushed", 64'(flushed_cnt - base_flushed), 64'(0));

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gather_bytes.md
GATHER_BYTES -- requirements
Module: gather_bytes

Interface
REQ-001 SHALL have parameter C_IN_BYTES, default 1, bytes read from the input FWFT FIFO per read.
REQ-002 SHALL have parameter C_OUT_BYTES, default 4, bytes written per output word; it SHALL be an integer multiple of C_IN_BYTES, and C_OUT_BYTES >= C_IN_BYTES.
REQ-003 SHALL have derived parameters C_IN_WIDTH=8*C_IN_BYTES, C_OUT_WIDTH=8*C_OUT_BYTES, C_MULT=C_OUT_BYTES/C_IN_BYTES, C_CNT_WIDTH=clog2(C_OUT_BYTES+1).
REQ-004 SHALL have port CLK, input, 1, the single clock.
REQ-005 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port INDATA_EN, input, 1, FWFT input data valid.
REQ-007 SHALL have port INDATA, input, C_IN_WIDTH, narrow input data.
REQ-008 SHALL have port INDATA_RD_EN, output, 1, input data consumed this cycle.
REQ-009 SHALL have port FLUSH, input, 1, pulse: emit any partial word once input runs dry.
REQ-010 SHALL have port FLUSHED, output, 1, one-cycle pulse when all flushed data has been written.
REQ-011 SHALL have port OUTDATA, output, C_OUT_WIDTH, wide output word.
REQ-012 SHALL have port OUTDATA_BYTES, output, C_CNT_WIDTH, valid byte count of OUTDATA, which is C_OUT_BYTES for a full word and less for a flushed partial word.
REQ-013 SHALL have port OUTDATA_WEN, output, 1, output write strobe.
REQ-014 SHALL have port OUTDATA_FULL, input, 1, downstream cannot accept a write.

Function
REQ-015 SHALL hold an accumulator (C_MULT slots), slot counter rPos (0..C_MULT-1), an output register with valid flag rOutValid and byte count, and a flush state machine with states RUN, DRAIN and DONE.
REQ-016 SHALL place the k-th input chunk of a word in OUTDATA[k*C_IN_WIDTH +: C_IN_WIDTH], with the first chunk in the least significant slot.
REQ-017 SHALL drive OUTDATA_WEN = rOutValid && !OUTDATA_FULL; a write SHALL clear rOutValid unless a new word is loaded in the same cycle.
REQ-018 SHALL drive INDATA_RD_EN = INDATA_EN && state!=DONE && (rPos!=C_MULT-1 || !rOutValid || !OUTDATA_FULL), which is combinational with no bubble.
REQ-019 On a read with rPos<C_MULT-1, SHALL store INDATA in slot rPos and increment rPos.
REQ-020 On a read with rPos==C_MULT-1, SHALL load the completed word into the output register in the same cycle, set OUTDATA_BYTES=C_OUT_BYTES, set rOutValid, and wrap rPos to 0.
REQ-021 Latency: a completed word SHALL be presented (OUTDATA_WEN high if not full) on the cycle after its last chunk is read; sustained throughput SHALL be one input read per cycle while OUTDATA_FULL is low.
REQ-022 RUN->DRAIN SHALL occur when FLUSH=1; FLUSH while in DRAIN SHALL have no further effect.
REQ-023 In DRAIN with INDATA_EN=0, rPos!=0 and (rOutValid=0 or a write occurs this cycle), SHALL load the partial word with unfilled slots zero, set OUTDATA_BYTES=rPos*C_IN_BYTES, and set rPos to 0.
REQ-024 DRAIN->DONE SHALL occur when INDATA_EN=0, rPos==0 and rOutValid==0; in DRAIN with INDATA_EN=1, SHALL keep consuming normally.
REQ-025 FLUSHED SHALL be high exactly while in DONE (one cycle); DONE SHALL transition to DRAIN if FLUSH=1 that cycle, otherwise to RUN.
REQ-026 A FLUSH with nothing buffered and input empty SHALL still produce FLUSHED two cycles after the FLUSH pulse, with no write.
REQ-027 SHALL never emit a word with OUTDATA_BYTES=0.

Reset
REQ-028 RST_N low SHALL asynchronously clear rPos, rOutValid, the accumulator and the output register to 0, and set the state to RUN.
REQ-029 During reset, INDATA_RD_EN, OUTDATA_WEN and FLUSHED SHALL be 0, OUTDATA SHALL be 0 and OUTDATA_BYTES SHALL be 0.
REQ-030 Reset asserted mid-word or mid-flush SHALL discard buffered data and pending flush with no write and no FLUSHED pulse.

Verification (C_IN_BYTES=1, C_OUT_BYTES=4)
REQ-031 Stream bytes 01,02,03,04,05..08 with FULL=0 -> writes 0x04030201 then 0x08070605, each with BYTES=4, one cycle after the 4th byte; INDATA_RD_EN high every cycle.
REQ-032 FULL=1 with a word pending and 3 more bytes buffered -> the 4th byte is not read (INDATA_RD_EN=0) and OUTDATA is held; FULL drops -> write and read occur in the same cycle.
REQ-033 Bytes AA,BB then FLUSH with input empty -> one write of 0x0000BBAA with BYTES=2, then a FLUSHED single-cycle pulse, then state RUN.
REQ-034 FLUSH with no data -> no write; FLUSHED pulses 2 cycles later; FLUSH asserted during FLUSHED -> a second FLUSHED pulse.
REQ-035 FLUSH while 6 bytes are still in the input FIFO -> one full word, then a 2-byte partial word, then FLUSHED.
REQ-036 RST_N pulsed low after 3 bytes of a word -> outputs go 0 immediately; the next 4 bytes form a clean word.
